// File: rtl/interrupt_pkg.sv
`default_nettype none
// ============================================================================
// interrupt_pkg : shared types and sizing helpers for the interrupt controller
// Revision 1.0
// ============================================================================
package interrupt_pkg;

  localparam int DEFAULT_INTERRUPT_SOURCES = 4;
  localparam int DEFAULT_WORD_WIDTH        = 32;

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_ENTER  = 2'd1,
    IC_ACTIVE = 2'd2
  } ic_state_t;

  // A single source still needs a one-bit selector.
  function automatic int src_width(input int sources);
    return (sources > 1) ? $clog2(sources) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_slot.sv
`default_nettype none
// ============================================================================
// interrupt_slot : one-deep message buffer with req/ack capture and clear port
// Revision 1.0
// ============================================================================
module interrupt_slot #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [WORD_WIDTH-1:0] bus_in,
  input  logic [WORD_WIDTH-1:0] value_in,
  input  logic                  clear,
  output logic                  ack,
  output logic                  pending,
  output logic [WORD_WIDTH-1:0] bus,
  output logic [WORD_WIDTH-1:0] value
);

  logic                  pending_q, pending_d;
  logic                  ack_q, ack_d;
  logic [WORD_WIDTH-1:0] bus_q, bus_d;
  logic [WORD_WIDTH-1:0] value_q, value_d;

  always_comb begin
    pending_d = pending_q;
    ack_d     = 1'b0;
    bus_d     = bus_q;
    value_d   = value_q;
    // Clear takes precedence; a waiting sender is picked up on the next cycle.
    if (clear) begin
      pending_d = 1'b0;
    end else if (req && !pending_q) begin
      pending_d = 1'b1;
      ack_d     = 1'b1;
      bus_d     = bus_in;
      value_d   = value_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      bus_q     <= '0;
      value_q   <= '0;
    end else begin
      pending_q <= pending_d;
      ack_q     <= ack_d;
      bus_q     <= bus_d;
      value_q   <= value_d;
    end
  end

  assign ack     = ack_q;
  assign pending = pending_q;
  assign bus     = bus_q;
  assign value   = value_q;

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// interrupt_controller : buffers per-source messages, arbitrates lowest-index,
// delivers as a context switch or a polled receive.      Revision 1.0
// ============================================================================
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int WORD_WIDTH        = DEFAULT_WORD_WIDTH,
  parameter int INTERRUPT_SOURCES = DEFAULT_INTERRUPT_SOURCES
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [INTERRUPT_SOURCES-1:0]            int_req,
  input  logic [INTERRUPT_SOURCES*WORD_WIDTH-1:0] int_bus_in,
  input  logic [INTERRUPT_SOURCES*WORD_WIDTH-1:0] int_value_in,
  output logic [INTERRUPT_SOURCES-1:0]            int_ack,
  input  logic [INTERRUPT_SOURCES-1:0]            enable_mask,
  input  logic                                    load_last,
  input  logic                                    recv_request,
  input  logic                                    return_interrupt,
  input  logic                                    halt_in,
  output logic                                    interrupt_active,
  output logic                                    handle_interrupt,
  output logic                                    servicing_interrupt,
  output logic [WORD_WIDTH-1:0]                   interrupt_bus,
  output logic [WORD_WIDTH-1:0]                   interrupt_value,
  output logic                                    recv_halt
);

  localparam int SRC_WIDTH = src_width(INTERRUPT_SOURCES);

  logic [INTERRUPT_SOURCES-1:0] pending;
  logic [INTERRUPT_SOURCES-1:0] slot_clear;
  logic [WORD_WIDTH-1:0]        slot_bus   [INTERRUPT_SOURCES];
  logic [WORD_WIDTH-1:0]        slot_value [INTERRUPT_SOURCES];

  logic [INTERRUPT_SOURCES-1:0] ctx_cand, poll_cand;
  logic [SRC_WIDTH-1:0]         ctx_sel, poll_sel;
  logic                         ctx_any, poll_any, poll_deliver;

  ic_state_t            state_q, state_d;
  logic [SRC_WIDTH-1:0] sel_q, sel_d;

  for (genvar i = 0; i < INTERRUPT_SOURCES; i++) begin : g_slot
    interrupt_slot #(
      .WORD_WIDTH (WORD_WIDTH)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .req      (int_req[i]),
      .bus_in   (int_bus_in[i*WORD_WIDTH +: WORD_WIDTH]),
      .value_in (int_value_in[i*WORD_WIDTH +: WORD_WIDTH]),
      .clear    (slot_clear[i]),
      .ack      (int_ack[i]),
      .pending  (pending[i]),
      .bus      (slot_bus[i]),
      .value    (slot_value[i])
    );
  end

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    ctx_cand  = pending & enable_mask;
    poll_cand = pending & ~enable_mask;
    ctx_any   = |ctx_cand;
    poll_any  = |poll_cand;
    ctx_sel   = '0;
    poll_sel  = '0;
    for (int i = INTERRUPT_SOURCES - 1; i >= 0; i--) begin
      if (ctx_cand[i])  ctx_sel  = SRC_WIDTH'(i);
      if (poll_cand[i]) poll_sel = SRC_WIDTH'(i);
    end
    // A context-switch candidate always beats a polled receive.
    poll_deliver = (state_q == IC_IDLE) && recv_request && !ctx_any
                   && poll_any && !load_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IC_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IC_IDLE: begin
        if (ctx_any) begin
          state_d = IC_ENTER;
          sel_d   = ctx_sel;
        end
      end
      IC_ENTER: begin
        if (!load_last) state_d = IC_ACTIVE;
      end
      IC_ACTIVE: begin
        if (return_interrupt && !halt_in) state_d = IC_IDLE;
      end
      default: state_d = IC_IDLE;
    endcase
  end

  // handle_interrupt is a request held until the conveyor takes it (load_last low).
  always_comb begin
    interrupt_active    = 1'b0;
    handle_interrupt    = 1'b0;
    servicing_interrupt = 1'b0;
    interrupt_bus       = '0;
    interrupt_value     = '0;
    recv_halt           = 1'b0;
    slot_clear          = '0;
    case (state_q)
      IC_IDLE: begin
        if (poll_deliver) begin
          servicing_interrupt  = 1'b1;
          interrupt_bus        = slot_bus[poll_sel];
          interrupt_value      = slot_value[poll_sel];
          slot_clear[poll_sel] = 1'b1;
        end
        recv_halt = recv_request && !poll_deliver;
      end
      IC_ENTER: begin
        handle_interrupt = 1'b1;
        interrupt_bus    = slot_bus[sel_q];
        interrupt_value  = slot_value[sel_q];
        if (!load_last) slot_clear[sel_q] = 1'b1;
        recv_halt = recv_request;
      end
      IC_ACTIVE: begin
        interrupt_active = 1'b1;
        recv_halt        = recv_request;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// tb_interrupt_controller : directed stimulus with a queue-based scoreboard
// Revision 1.0
// ============================================================================
module tb_interrupt_controller;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   int_req;
  logic [N*W-1:0] int_bus_in, int_value_in;
  logic [N-1:0]   int_ack;
  logic [N-1:0]   enable_mask;
  logic           load_last, recv_request, return_interrupt, halt_in;
  logic           interrupt_active, handle_interrupt, servicing_interrupt, recv_halt;
  logic [W-1:0]   interrupt_bus, interrupt_value;

  interrupt_controller #(.WORD_WIDTH(W), .INTERRUPT_SOURCES(N)) dut (
    .clk                 (clk),
    .reset               (reset),
    .int_req             (int_req),
    .int_bus_in          (int_bus_in),
    .int_value_in        (int_value_in),
    .int_ack             (int_ack),
    .enable_mask         (enable_mask),
    .load_last           (load_last),
    .recv_request        (recv_request),
    .return_interrupt    (return_interrupt),
    .halt_in             (halt_in),
    .interrupt_active    (interrupt_active),
    .handle_interrupt    (handle_interrupt),
    .servicing_interrupt (servicing_interrupt),
    .interrupt_bus       (interrupt_bus),
    .interrupt_value     (interrupt_value),
    .recv_halt           (recv_halt)
  );

  always #5 clk = ~clk;

  // kind = {servicing, handle}
  typedef struct packed {
    logic [1:0]   kind;
    logic [W-1:0] bus;
    logic [W-1:0] value;
  } del_t;

  localparam logic [1:0] K_HANDLE = 2'b01;
  localparam logic [1:0] K_SERV   = 2'b10;

  logic [N-1:0] exp_ack_q [$];
  del_t         exp_del_q [$];
  del_t         cur;
  logic         prev_handle = 1'b0;
  int           checks = 0;
  int           passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #2;
  endtask

  task automatic send(input int i, input logic [W-1:0] b, input logic [W-1:0] v);
    int_req[i]             = 1'b1;
    int_bus_in[i*W +: W]   = b;
    int_value_in[i*W +: W] = v;
  endtask

  task automatic push_del(input logic [1:0] k, input logic [W-1:0] b, input logic [W-1:0] v);
    del_t d;
    d.kind = k; d.bus = b; d.value = v;
    exp_del_q.push_back(d);
  endtask

  // Monitor: pops expectations whenever the DUT presents an ack or a delivery.
  always @(negedge clk) begin
    if (int_ack != '0) begin
      if (exp_ack_q.size() == 0) chk("unexpected_ack", 64'(int_ack), 64'd0);
      else chk("int_ack", 64'(int_ack), 64'(exp_ack_q.pop_front()));
    end
    if (handle_interrupt || servicing_interrupt) begin
      chk("strobe_exclusive", 64'(handle_interrupt && servicing_interrupt), 64'd0);
      chk("serv_vs_load_last", 64'(servicing_interrupt && load_last), 64'd0);
      if (servicing_interrupt || !prev_handle) begin
        if (exp_del_q.size() == 0) begin
          chk("unexpected_delivery", 64'({servicing_interrupt, handle_interrupt}), 64'd0);
        end else begin
          cur = exp_del_q.pop_front();
          chk("delivery_kind", 64'({servicing_interrupt, handle_interrupt}), 64'(cur.kind));
          chk("delivery_bus", 64'(interrupt_bus), 64'(cur.bus));
          chk("delivery_value", 64'(interrupt_value), 64'(cur.value));
        end
      end else begin
        chk("held_bus", 64'(interrupt_bus), 64'(cur.bus));
        chk("held_value", 64'(interrupt_value), 64'(cur.value));
      end
    end else begin
      chk("idle_bus_value_zero", {interrupt_bus, interrupt_value}, 64'd0);
    end
    prev_handle = handle_interrupt;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; int_req = '0; int_bus_in = '0; int_value_in = '0;
    enable_mask = '0; load_last = 1'b0; recv_request = 1'b0;
    return_interrupt = 1'b0; halt_in = 1'b0;
    repeat (3) tick();
    sample();
    chk("rst_ack", 64'(int_ack), 64'd0);
    chk("rst_active", 64'(interrupt_active), 64'd0);
    chk("rst_handle", 64'(handle_interrupt), 64'd0);
    chk("rst_serv", 64'(servicing_interrupt), 64'd0);
    chk("rst_recv_halt", 64'(recv_halt), 64'd0);
    chk("rst_bus_value", {interrupt_bus, interrupt_value}, 64'd0);
    reset = 1'b0;
    tick();

    // Basic context switch and latency
    enable_mask = 4'b0100; send(2, 32'h1000, 32'h55);
    exp_ack_q.push_back(4'b0100); push_del(K_HANDLE, 32'h1000, 32'h55);
    tick(); int_req = '0;
    tick(); sample(); chk("t1_handle_c2", 64'(handle_interrupt), 64'd1);
    tick(); sample(); chk("t1_active_c3", 64'(interrupt_active), 64'd1);
    chk("t1_handle_c3", 64'(handle_interrupt), 64'd0);
    tick();
    tick(); return_interrupt = 1'b1;
    tick(); return_interrupt = 1'b0; sample();
    chk("t1_active_c6", 64'(interrupt_active), 64'd0);

    // Two simultaneous requests: lowest enabled index first
    enable_mask = 4'b1010;
    send(1, 32'h2001, 32'h11); send(3, 32'h2003, 32'h33);
    exp_ack_q.push_back(4'b1010);
    push_del(K_HANDLE, 32'h2001, 32'h11); push_del(K_HANDLE, 32'h2003, 32'h33);
    tick(); int_req = '0;
    tick();
    tick(); sample(); chk("t2_active_first", 64'(interrupt_active), 64'd1);
    tick(); return_interrupt = 1'b1;
    tick(); return_interrupt = 1'b0; sample();
    chk("t2_idle_between", 64'(interrupt_active), 64'd0);
    tick(); sample(); chk("t2_handle_second", 64'(handle_interrupt), 64'd1);
    tick(); sample(); chk("t2_active_second", 64'(interrupt_active), 64'd1);
    return_interrupt = 1'b1;
    tick(); return_interrupt = 1'b0;

    // ENTER held while load_last is high
    enable_mask = 4'b0001; send(0, 32'h3000, 32'h99);
    exp_ack_q.push_back(4'b0001); push_del(K_HANDLE, 32'h3000, 32'h99);
    tick(); int_req = '0; load_last = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("t3_handle_held", 64'(handle_interrupt), 64'd1);
      chk("t3_not_active", 64'(interrupt_active), 64'd0);
      tick();
    end
    load_last = 1'b0; sample();
    chk("t3_handle_4th", 64'(handle_interrupt), 64'd1);
    tick(); sample();
    chk("t3_active", 64'(interrupt_active), 64'd1);
    chk("t3_handle_off", 64'(handle_interrupt), 64'd0);
    return_interrupt = 1'b1;
    tick(); return_interrupt = 1'b0;

    // Polled receive on a masked source
    enable_mask = 4'b0000; send(0, 32'h4000, 32'h7);
    exp_ack_q.push_back(4'b0001); push_del(K_SERV, 32'h4000, 32'h7);
    tick(); int_req = '0;
    tick(); recv_request = 1'b1; load_last = 1'b1; sample();
    chk("t4_halt_load_last", 64'(recv_halt), 64'd1);
    chk("t4_no_serv_load_last", 64'(servicing_interrupt), 64'd0);
    tick(); load_last = 1'b0; sample();
    chk("t4_serv", 64'(servicing_interrupt), 64'd1);
    chk("t4_no_halt", 64'(recv_halt), 64'd0);
    tick(); sample();
    chk("t4_halt_empty", 64'(recv_halt), 64'd1);
    chk("t4_no_serv_empty", 64'(servicing_interrupt), 64'd0);
    recv_request = 1'b0;
    tick();

    // No nesting while ACTIVE; return ignored under halt_in
    enable_mask = 4'b0101; send(2, 32'h5002, 32'h22);
    exp_ack_q.push_back(4'b0100); push_del(K_HANDLE, 32'h5002, 32'h22);
    tick(); int_req = '0;
    tick();
    tick(); send(0, 32'h5000, 32'h0A);
    exp_ack_q.push_back(4'b0001); push_del(K_HANDLE, 32'h5000, 32'h0A);
    tick(); int_req = '0;
    tick(); recv_request = 1'b1; sample();
    chk("t5_no_nest", 64'(handle_interrupt), 64'd0);
    chk("t5_still_active", 64'(interrupt_active), 64'd1);
    chk("t5_recv_halt", 64'(recv_halt), 64'd1);
    chk("t5_no_serv", 64'(servicing_interrupt), 64'd0);
    tick(); recv_request = 1'b0; return_interrupt = 1'b1; halt_in = 1'b1;
    tick(); sample();
    chk("t5_halt_blocks_return", 64'(interrupt_active), 64'd1);
    halt_in = 1'b0;
    tick(); return_interrupt = 1'b0; sample();
    chk("t5_returned", 64'(interrupt_active), 64'd0);
    chk("t5_idle_no_handle", 64'(handle_interrupt), 64'd0);
    tick(); sample(); chk("t5_pending_enters", 64'(handle_interrupt), 64'd1);
    tick(); sample(); chk("t5_active_again", 64'(interrupt_active), 64'd1);
    return_interrupt = 1'b1;
    tick(); return_interrupt = 1'b0;

    // Reset in ENTER and in ACTIVE
    enable_mask = 4'b0010; send(1, 32'h6001, 32'h61);
    exp_ack_q.push_back(4'b0010); push_del(K_HANDLE, 32'h6001, 32'h61);
    tick(); int_req = '0;
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; sample();
    chk("t6_enter_rst_handle", 64'(handle_interrupt), 64'd0);
    chk("t6_enter_rst_active", 64'(interrupt_active), 64'd0);
    chk("t6_enter_rst_ack", 64'(int_ack), 64'd0);
    tick(); sample();
    chk("t6_pending_cleared", 64'(handle_interrupt), 64'd0);
    send(1, 32'h6101, 32'h71);
    exp_ack_q.push_back(4'b0010); push_del(K_HANDLE, 32'h6101, 32'h71);
    tick(); int_req = '0;
    tick();
    tick(); sample(); chk("t6_active", 64'(interrupt_active), 64'd1);
    reset = 1'b1; send(1, 32'h6202, 32'h72);
    exp_ack_q.push_back(4'b0010); push_del(K_HANDLE, 32'h6202, 32'h72);
    tick(); reset = 1'b0; sample();
    chk("t6_active_rst", 64'(interrupt_active), 64'd0);
    chk("t6_no_ack_in_reset", 64'(int_ack), 64'd0);
    tick(); int_req = '0;
    tick();
    tick(); sample(); chk("t6_reacked_active", 64'(interrupt_active), 64'd1);
    return_interrupt = 1'b1;
    tick(); return_interrupt = 1'b0; sample();
    chk("t6_final_idle", 64'(interrupt_active), 64'd0);

    repeat (3) tick();
    chk("ack_queue_drained", 64'(exp_ack_q.size()), 64'd0);
    chk("delivery_queue_drained", 64'(exp_del_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
